// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: shares one DRAM master FIFO between the I-cache and D-cache
// memory-request ports. One transaction in flight, round-robin on contention,
// read data routed back to the requester that issued the read, sticky debug
// flags for response timeouts and responses nobody asked for.
module dram_req_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  input  logic              i_req_rw,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_data,
  input  logic              d_req_rw,
  input  logic              d_req_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  output logic              i_rsp_ready,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_ready,
  output logic              fifo_req_cmd,
  output logic [ADDR_W-1:0] fifo_req_addr,
  output logic [DATA_W-1:0] fifo_req_data,
  output logic              fifo_req_en,
  input  logic              fifo_req_rdy,
  input  logic [DATA_W-1:0] fifo_rsp_data,
  input  logic              fifo_rsp_en,
  output logic              fifo_rsp_rdy,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_spurious
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_last_grant;   // 0 = I-cache, 1 = D-cache
  logic              r_owner;        // requester of the transaction in flight
  logic              r_cmd;          // 1 = read, 0 = write (FIFO encoding)
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rsp_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err_timeout;
  logic              r_err_spurious;

  logic              w_any_valid;
  logic              w_grant_d;
  logic              w_push;
  logic              w_wait_idle;
  logic [CNT_W-1:0]  w_cnt_inc;

  // On a tie the requester that did not win last time gets the grant.
  assign w_any_valid = i_req_valid | d_req_valid;
  assign w_grant_d   = d_req_valid & (~i_req_valid | ~r_last_grant);
  assign w_push      = (r_state == S_ISSUE) & fifo_req_rdy;
  assign w_wait_idle = (r_state == S_WAIT_RSP) & ~fifo_rsp_en;
  assign w_cnt_inc   = r_cnt + 1'b1;

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and FSM-driven outputs.
  always_comb begin
    w_state_next  = r_state;
    fifo_req_en   = 1'b0;
    i_rsp_ready   = 1'b0;
    d_rsp_ready   = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:     if (w_any_valid) w_state_next = S_ISSUE;
      S_ISSUE: begin
        fifo_req_en = fifo_req_rdy;
        if (fifo_req_rdy) w_state_next = r_cmd ? S_WAIT_RSP : S_RESP;
      end
      S_WAIT_RSP: if (fifo_rsp_en) w_state_next = S_RESP;
      S_RESP: begin
        i_rsp_ready  = ~r_owner;
        d_rsp_ready  = r_owner;
        w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Capture the granted request and remember who won for round-robin.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_last_grant <= 1'b0;
      r_owner      <= 1'b0;
      r_cmd        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else if (r_state == S_IDLE && w_any_valid) begin
      r_last_grant <= w_grant_d;
      r_owner      <= w_grant_d;
      r_cmd        <= w_grant_d ? ~d_req_rw : ~i_req_rw;
      r_addr       <= w_grant_d ? d_req_addr : i_req_addr;
      r_data       <= w_grant_d ? d_req_data : i_req_data;
    end
  end

  // Read-response register; writes leave it untouched.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                                      r_rsp_data <= '0;
    else if (r_state == S_WAIT_RSP && fifo_rsp_en)  r_rsp_data <= fifo_rsp_data;
  end

  // Wait counter: cleared on the read push, saturates at TIMEOUT.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                                               r_cnt <= '0;
    else if (w_push)                                         r_cnt <= '0;
    else if (w_wait_idle && r_cnt != CNT_W'(TIMEOUT))        r_cnt <= w_cnt_inc;
  end

  // Sticky debug flags; the flag rises in the same cycle the counter hits TIMEOUT.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_wait_idle && w_cnt_inc == CNT_W'(TIMEOUT)) r_err_timeout <= 1'b1;
      if (fifo_rsp_en && r_state != S_WAIT_RSP)        r_err_spurious <= 1'b1;
    end
  end

  assign fifo_req_cmd  = r_cmd;
  assign fifo_req_addr = r_addr;
  assign fifo_req_data = r_data;
  assign fifo_rsp_rdy  = 1'b1;
  assign i_rsp_data    = r_rsp_data;
  assign d_rsp_data    = r_rsp_data;
  assign err_timeout   = r_err_timeout;
  assign err_spurious  = r_err_spurious;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Bench for dram_req_arbiter: directed scenarios plus randomized rounds, with a
// transaction-level model (expected push queue, round-robin rule, response
// owner/data) predicting every push and every ready pulse.
`timescale 1ns/1ps
module tb_dram_req_arbiter;
  localparam int AW = 27;
  localparam int DW = 128;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] i_req_addr, d_req_addr;
  logic [DW-1:0] i_req_data, d_req_data;
  logic          i_req_rw, d_req_rw, i_req_valid, d_req_valid;
  logic [DW-1:0] i_rsp_data, d_rsp_data;
  logic          i_rsp_ready, d_rsp_ready;
  logic          fifo_req_cmd;
  logic [AW-1:0] fifo_req_addr;
  logic [DW-1:0] fifo_req_data;
  logic          fifo_req_en, fifo_req_rdy;
  logic [DW-1:0] fifo_rsp_data;
  logic          fifo_rsp_en, fifo_rsp_rdy;
  logic          busy, err_timeout, err_spurious;

  always #5 sys_clk = ~sys_clk;

  dram_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_rw(i_req_rw), .i_req_valid(i_req_valid),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_rw(d_req_rw), .d_req_valid(d_req_valid),
    .i_rsp_data(i_rsp_data), .i_rsp_ready(i_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
    .fifo_req_cmd(fifo_req_cmd), .fifo_req_addr(fifo_req_addr), .fifo_req_data(fifo_req_data),
    .fifo_req_en(fifo_req_en), .fifo_req_rdy(fifo_req_rdy),
    .fifo_rsp_data(fifo_rsp_data), .fifo_rsp_en(fifo_rsp_en), .fifo_rsp_rdy(fifo_rsp_rdy),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
  );

  typedef struct {
    bit            port;   // 0 = I, 1 = D
    bit            cmd;    // 1 = read
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } push_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester-side stimulus, index 0 = I, 1 = D.
  bit            pend [2];
  bit            rrw  [2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rdata[2];

  // Reference model state.
  push_t         exp_q[$];
  bit            m_last;
  logic [DW-1:0] m_rsp;
  bit            exp_to;
  bit            exp_spur;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic drive();
    i_req_valid = pend[0]; i_req_rw = rrw[0]; i_req_addr = raddr[0]; i_req_data = rdata[0];
    d_req_valid = pend[1]; d_req_rw = rrw[1]; d_req_addr = raddr[1]; d_req_data = rdata[1];
  endtask

  task automatic add_exp(input bit p);
    push_t e;
    e.port = p; e.cmd = ~rrw[p]; e.addr = raddr[p]; e.data = rdata[p];
    exp_q.push_back(e);
  endtask

  // Raise requests together while idle; model predicts grant order.
  task automatic new_round(input bit wi, input bit wd, input int rwmode);
    bit first;
    for (int p = 0; p < 2; p++) begin
      raddr[p] = AW'($urandom);
      rdata[p] = {$urandom, $urandom, $urandom, $urandom};
      rrw[p]   = (rwmode == 2) ? 1'($urandom_range(0, 1)) : (rwmode == 1);
    end
    pend[0] = wi; pend[1] = wd;
    if (wi && wd) begin
      first = ~m_last;
      add_exp(first); add_exp(~first);
      m_last = ~first;
    end else if (wi) begin
      add_exp(1'b0); m_last = 1'b0;
    end else begin
      add_exp(1'b1); m_last = 1'b1;
    end
  endtask

  task automatic do_reset();
    pend[0] = 0; pend[1] = 0;
    drive();
    fifo_rsp_en = 0; fifo_req_rdy = 1; rstn = 0;
    @(negedge sys_clk);
    chk("rst_i_ready", i_rsp_ready, 0);
    chk("rst_d_ready", d_rsp_ready, 0);
    chk("rst_req_en", fifo_req_en, 0);
    chk("rst_req_cmd", fifo_req_cmd, 0);
    chk("rst_req_addr", fifo_req_addr, 0);
    chk("rst_req_data", fifo_req_data, 0);
    chk("rst_i_rsp_data", i_rsp_data, 0);
    chk("rst_d_rsp_data", d_rsp_data, 0);
    chk("rst_rsp_rdy", fifo_rsp_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_spurious", err_spurious, 0);
    adv();
    rstn = 1;
    m_last = 0; m_rsp = '0; exp_to = 0; exp_spur = 0;
    exp_q.delete();
  endtask

  // Act as the FIFO until all pending requests complete; every cycle compares
  // ready pulses, push contents and error flags with the model.
  task automatic serve(input int low_cycles, input bit rnd_rdy, input int fixed_dly);
    int            start;
    bit            outst;
    int            rsp_at;
    int            push_cyc;
    bit            cur_port;
    bit            want;
    int            want_cyc;
    bit            want_port;
    logic [DW-1:0] want_data;
    logic [DW-1:0] rsp_val;
    push_t         e;
    start = cyc; outst = 0; rsp_at = 0; push_cyc = 0; cur_port = 0;
    want = 0; want_cyc = 0; want_port = 0; want_data = '0; rsp_val = '0;
    while (pend[0] || pend[1] || want || outst) begin
      checks++;
      assert (cyc - start <= 200) else begin
        errors++;
        $error("FAIL serve_budget observed=%0d cycles expected<=200", cyc - start);
        pend[0] = 0; pend[1] = 0;
        break;
      end
      drive();
      fifo_req_rdy  = (cyc - start <= low_cycles) ? 1'b0 :
                      (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
      fifo_rsp_en   = outst && (cyc == rsp_at);
      fifo_rsp_data = fifo_rsp_en ? rsp_val : {$urandom, $urandom, $urandom, $urandom};
      @(negedge sys_clk);
      if (outst && cyc >= push_cyc + TO + 1) exp_to = 1;
      chk("err_timeout", err_timeout, exp_to);
      chk("err_spurious", err_spurious, exp_spur);
      chk("i_ready", i_rsp_ready, want && want_cyc == cyc && !want_port);
      chk("d_ready", d_rsp_ready, want && want_cyc == cyc && want_port);
      if (!fifo_req_rdy) chk("en_without_rdy", fifo_req_en, 0);
      if (want && want_cyc == cyc) begin
        chk("rsp_data", want_port ? d_rsp_data : i_rsp_data, want_data);
        pend[want_port] = 0;
        want = 0;
      end
      if (fifo_req_en) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_push observed=push expected=none addr=%0h", fifo_req_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("push_cmd", fifo_req_cmd, e.cmd);
          chk("push_addr", fifo_req_addr, e.addr);
          chk("push_data", fifo_req_data, e.data);
          if (low_cycles > 0) chk("push_cycle", cyc - start, low_cycles + 1);
          cur_port = e.port;
          if (e.cmd) begin
            outst    = 1;
            push_cyc = cyc;
            rsp_at   = cyc + ((fixed_dly > 0) ? fixed_dly : $urandom_range(1, 5));
            rsp_val  = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            want = 1; want_cyc = cyc + 1; want_port = e.port; want_data = m_rsp;
          end
        end
      end
      if (fifo_rsp_en) begin
        m_rsp = rsp_val; outst = 0;
        want = 1; want_cyc = cyc + 1; want_port = cur_port; want_data = rsp_val;
      end
      adv();
    end
    fifo_rsp_en = 0;
    fifo_req_rdy = 1;
  endtask

  task automatic idle_check(input string tag);
    drive();
    @(negedge sys_clk);
    chk(tag, busy, 0);
    adv();
  endtask

  initial begin
    rstn = 0; fifo_req_rdy = 1; fifo_rsp_en = 0; fifo_rsp_data = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; rrw[p] = 0; raddr[p] = '0; rdata[p] = '0;
    end
    drive();
    adv();
    do_reset();

    // Single D read with response at cycle 5.
    pend[1] = 1; rrw[1] = 0; raddr[1] = 27'h40; rdata[1] = '0;
    drive(); @(negedge sys_clk);
    chk("t1_c0_busy", busy, 0); chk("t1_c0_en", fifo_req_en, 0);
    adv();
    drive(); @(negedge sys_clk);
    chk("t1_c1_en", fifo_req_en, 1); chk("t1_c1_cmd", fifo_req_cmd, 1);
    chk("t1_c1_addr", fifo_req_addr, 27'h40); chk("t1_c1_busy", busy, 1);
    adv();
    for (int k = 2; k <= 4; k++) begin
      drive(); @(negedge sys_clk);
      chk("t1_wait_en", fifo_req_en, 0); chk("t1_wait_dready", d_rsp_ready, 0);
      adv();
    end
    drive(); fifo_rsp_en = 1; fifo_rsp_data = {4{32'hDEADBEEF}};
    @(negedge sys_clk);
    chk("t1_c5_dready", d_rsp_ready, 0);
    adv();
    fifo_rsp_en = 0; fifo_rsp_data = '0; drive();
    @(negedge sys_clk);
    chk("t1_c6_dready", d_rsp_ready, 1); chk("t1_c6_iready", i_rsp_ready, 0);
    chk("t1_c6_data", d_rsp_data, {4{32'hDEADBEEF}});
    adv();
    pend[1] = 0; drive();
    @(negedge sys_clk);
    chk("t1_c7_busy", busy, 0); chk("t1_c7_dready", d_rsp_ready, 0);
    chk("t1_c7_shared_data", i_rsp_data, {4{32'hDEADBEEF}});
    adv();

    // Ties after reset: D, then I, then D again on the next tie.
    do_reset();
    new_round(1, 1, 0); serve(0, 0, 0); idle_check("t2_idle_a");
    new_round(1, 1, 0); serve(0, 0, 0); idle_check("t2_idle_b");

    // I write held in ISSUE by 4 cycles of fifo_req_rdy low.
    new_round(1, 0, 1); serve(4, 0, 0); idle_check("t3_idle");

    // Randomized rounds: random mix of requesters, rw, FIFO readiness, latency.
    for (int r = 0; r < 30; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      new_round(sel[0], sel[1], 2);
      serve(0, 1, 0);
      idle_check("rnd_idle");
    end

    // Spurious response in IDLE, then a normal read.
    drive(); fifo_rsp_en = 1; fifo_rsp_data = {4{$urandom}};
    @(negedge sys_clk);
    chk("t4_spur_before", err_spurious, 0);
    adv();
    fifo_rsp_en = 0; drive();
    @(negedge sys_clk);
    chk("t4_spur_set", err_spurious, 1); chk("t4_iready", i_rsp_ready, 0);
    chk("t4_dready", d_rsp_ready, 0); chk("t4_busy", busy, 0);
    adv();
    exp_spur = 1;
    new_round(0, 1, 0); serve(0, 0, 0); idle_check("t4_idle");

    // No response for 12 cycles: timeout flag rises, late response still completes.
    new_round(0, 1, 0); serve(0, 0, 12); idle_check("t5_idle");
    chk("t5_timeout_sticky", err_timeout, 1);

    // Reset while waiting for a read response, then a stale response.
    pend[1] = 1; rrw[1] = 0; raddr[1] = 27'h123; rdata[1] = '0; fifo_req_rdy = 1;
    drive(); @(negedge sys_clk); adv();
    drive(); @(negedge sys_clk); chk("t6_push", fifo_req_en, 1); adv();
    drive(); @(negedge sys_clk); chk("t6_wait_busy", busy, 1); adv();
    do_reset();
    drive(); fifo_rsp_en = 1; fifo_rsp_data = {4{$urandom}};
    @(negedge sys_clk);
    chk("t6_stale_busy", busy, 0); chk("t6_stale_dready", d_rsp_ready, 0);
    adv();
    fifo_rsp_en = 0; drive();
    @(negedge sys_clk);
    chk("t6_spur_set", err_spurious, 1); chk("t6_dready", d_rsp_ready, 0);
    chk("t6_iready", i_rsp_ready, 0); chk("t6_rsp_data", d_rsp_data, 0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
